rst_ctrl: RTL
=============

// Module: rst_ctrl
// PURPOSE
//  Reset initiator for the rv32i core. Collects reset requests from software, debug and an optional watchdog.
//  Quiesces the pipeline through a req/ack handshake, then drives a stretched active-low reset.
//  rst_n_o feeds the per-domain async-assert/sync-release synchronizers downstream.
//  Power-on reset arrives on rst_n_i and is stretched the same way.
// PARAMETERS
//  RST_CYCLES  16     cycles rst_n_o held low per reset event (>=2)
//  DRAIN_TMO   64     max cycles waiting for quiesce_ack_i before forcing reset (>=1)
//  WDT_CYCLES  65536  watchdog period in cycles (RST_WDT_EN only)
// PORTS
//  clk          in   1  single clock; all logic on posedge
//  rst_n_i      in   1  asynchronous, active-low reset (already sync-released upstream)
//  sw_req_i     in   1  software reset request, 1-cycle pulse or level
//  dbg_req_i    in   1  debug-module reset request, pulse or level
//  wdt_en_i     in   1  watchdog enable (ignored without RST_WDT_EN)
//  wdt_kick_i   in   1  watchdog reload pulse (ignored without RST_WDT_EN)
//  quiesce_ack_i in  1  core reports pipeline drained / bus idle
//  quiesce_req_o out 1  asks core to stop fetching and drain
//  rst_n_o      out  1  registered active-low reset to downstream synchronizers
//  cause_o      out  4  {tmo,wdt,dbg,sw} cause of last soft reset
// BEHAVIOUR
//  Reset (rst_n_i low, async): state=HOLD, cnt=RST_CYCLES-1, rst_n_o=0, quiesce_req_o=0,
//   cause_o=0, wdt counter=WDT_CYCLES-1.
//  States: HOLD -> RUN -> DRAIN -> HOLD.
//  HOLD: rst_n_o=0; cnt decrements each cycle; at cnt==0 -> RUN.
//   rst_n_o goes 1 on the clock edge entering RUN, so it is low for exactly RST_CYCLES cycles.
//  RUN: rst_n_o=1. Any of sw_req_i|dbg_req_i|wdt_expire sampled high -> DRAIN next cycle.
//   On that edge, cause_o is loaded with {0,wdt,dbg,sw}; all simultaneous sources are recorded.
//  DRAIN: quiesce_req_o=1 (registered, asserted on DRAIN entry); tmo counter counts DRAIN_TMO.
//   quiesce_ack_i=1 -> HOLD next cycle.
//   No ack after DRAIN_TMO cycles -> HOLD, and cause_o[3] is set.
//   Ack and timeout in the same cycle -> ack wins; tmo bit stays 0.
//   quiesce_req_o drops on HOLD entry.
//  Requests arriving in DRAIN or HOLD are ignored, not queued.
//   A level still high on RUN entry triggers a new DRAIN one cycle after RUN entry.
//  cause_o is cleared only by rst_n_i; it holds across soft resets so software can read it.
//  rst_n_i assertion mid-DRAIN or mid-HOLD aborts immediately to the reset values above.
//  Counters are $clog2-sized, unsigned, and never wrap: they stop at 0.
// CONFIGURATION
//  Macro RST_WDT_EN defined:
//   - Watchdog counter reloads to WDT_CYCLES-1 on wdt_kick_i, on RUN entry, or while wdt_en_i=0.
//   - Otherwise it decrements in RUN only.
//   - wdt_expire = (cnt==0 && wdt_en_i && RUN).
//   - Kick and expire in the same cycle -> kick wins.
//  Macro not defined:
//   - No watchdog logic; wdt_en_i and wdt_kick_i are unused.
//   - wdt_expire is tied 0, so cause_o[2] is always 0.
// STRUCTURE
//  define.vh: RST_ACTIVE/RST_RELEASE, state encodings RC_HOLD/RC_RUN/RC_DRAIN,
//   cause bit indices RC_CAUSE_SW/DBG/WDT/TMO.
//  One sub-module, rst_dn_cnt: loadable saturating down-counter with a zero flag.
//   It is instantiated for the HOLD stretch, the DRAIN timeout and the watchdog.
// TESTING
//  1. POR: release rst_n_i -> rst_n_o stays 0 for 16 clks, then 1. cause_o=0, quiesce_req_o=0.
//  2. sw_req_i pulse in RUN, ack after 5 clks -> quiesce_req_o high 5 clks.
//     Then rst_n_o low 16 clks. cause_o=4'b0001.
//  3. dbg_req_i with no ack -> DRAIN lasts 64 clks, then HOLD. cause_o=4'b1010.
//  4. sw and dbg high in the same cycle -> cause_o=4'b0011.
//     sw re-pulsed during HOLD -> no second reset.
//  5. RST_WDT_EN, WDT_CYCLES=32, wdt_en_i=1, no kick -> reset sequence starts, cause_o=4'b0100.
//     Kicking every 20 clks -> no reset ever.
//  6. rst_n_i asserted mid-DRAIN -> rst_n_o=0 and quiesce_req_o=0 asynchronously, cause_o=0.

Source files
------------

// File: rtl/rst_ctrl_pkg.sv
// Shared types and constants for the rv32i reset initiator.
// Cause-bit indices, reset polarity and the FSM state encoding live here.
package rst_ctrl_pkg;

    typedef enum logic [1:0] {
        RC_HOLD  = 2'd0,
        RC_RUN   = 2'd1,
        RC_DRAIN = 2'd2
    } rc_state_e;

    localparam logic RST_ACTIVE  = 1'b0;
    localparam logic RST_RELEASE = 1'b1;

    localparam int unsigned RC_CAUSE_W   = 4;
    localparam int unsigned RC_CAUSE_SW  = 0;
    localparam int unsigned RC_CAUSE_DBG = 1;
    localparam int unsigned RC_CAUSE_WDT = 2;
    localparam int unsigned RC_CAUSE_TMO = 3;

    // Width of a down-counter that must hold n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = (n <= 32'd2) ? 32'd1 : 32'(unsigned'($clog2(n)));
        return w;
    endfunction

endpackage

// File: rtl/rst_ctrl_dn_cnt.sv
// Loadable saturating down-counter with a registered zero flag.
// Load beats decrement; the count stops at zero instead of wrapping.
module rst_ctrl_dn_cnt #(
    parameter int unsigned     W    = 4,
    parameter logic [W-1:0]    INIT = '0
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = INIT;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Zero flag tracks the next count so it lines up with cnt_q.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= INIT;
            zero_q <= (INIT == '0);
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/rst_ctrl.sv
// Reset initiator: quiesces the core on sw/dbg/watchdog requests, then drives a stretched reset.
// Optional watchdog is built only when RST_WDT_EN is defined.
module rst_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned DRAIN_TMO  = 64,
    parameter int unsigned WDT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n_i,
    input  logic                  sw_req_i,
    input  logic                  dbg_req_i,
    input  logic                  wdt_en_i,
    input  logic                  wdt_kick_i,
    input  logic                  quiesce_ack_i,
    output logic                  quiesce_req_o,
    output logic                  rst_n_o,
    output logic [RC_CAUSE_W-1:0] cause_o
);

    localparam int unsigned          HOLD_W    = cnt_w(RST_CYCLES);
    localparam int unsigned          TMO_W     = cnt_w(DRAIN_TMO);
    localparam logic [HOLD_W-1:0]    HOLD_INIT = HOLD_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]     TMO_INIT  = TMO_W'(DRAIN_TMO - 1);

    rc_state_e             state_q, state_d;
    logic                  rst_n_q, rst_n_d;
    logic                  quiesce_q, quiesce_d;
    logic [RC_CAUSE_W-1:0] cause_q, cause_d;

    logic hold_zero_c, tmo_zero_c, wdt_expire_c;
    logic hold_load_c, tmo_load_c;

    assign hold_load_c = (state_d == RC_HOLD)  && (state_q != RC_HOLD);
    assign tmo_load_c  = (state_d == RC_DRAIN) && (state_q != RC_DRAIN);

    rst_ctrl_dn_cnt #(.W(HOLD_W), .INIT(HOLD_INIT)) u_hold_cnt (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .load_i  (hold_load_c),
        .dec_i   (state_q == RC_HOLD),
        .zero_o  (hold_zero_c)
    );

    rst_ctrl_dn_cnt #(.W(TMO_W), .INIT(TMO_INIT)) u_tmo_cnt (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .load_i  (tmo_load_c),
        .dec_i   (state_q == RC_DRAIN),
        .zero_o  (tmo_zero_c)
    );

`ifdef RST_WDT_EN
    localparam int unsigned       WDT_W    = cnt_w(WDT_CYCLES);
    localparam logic [WDT_W-1:0]  WDT_INIT = WDT_W'(WDT_CYCLES - 1);

    logic wdt_zero_c, wdt_load_c, run_entry_c;

    assign run_entry_c = (state_d == RC_RUN) && (state_q != RC_RUN);
    assign wdt_load_c  = wdt_kick_i || run_entry_c || !wdt_en_i;

    rst_ctrl_dn_cnt #(.W(WDT_W), .INIT(WDT_INIT)) u_wdt_cnt (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .load_i  (wdt_load_c),
        .dec_i   (state_q == RC_RUN),
        .zero_o  (wdt_zero_c)
    );

    // A kick in the expiry cycle rescues the core.
    assign wdt_expire_c = wdt_zero_c && wdt_en_i && (state_q == RC_RUN) && !wdt_kick_i;
`else
    localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
    logic unused_wdt_c;

    assign unused_wdt_c = wdt_en_i ^ wdt_kick_i;
    assign wdt_expire_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RC_HOLD;
            rst_n_q   <= RST_ACTIVE;
            quiesce_q <= 1'b0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            rst_n_q   <= rst_n_d;
            quiesce_q <= quiesce_d;
            cause_q   <= cause_d;
        end
    end

    // Next state; outputs are derived from the state being entered so they register with it.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            RC_HOLD: begin
                if (hold_zero_c) begin
                    state_d = RC_RUN;
                end
            end
            RC_RUN: begin
                if (sw_req_i || dbg_req_i || wdt_expire_c) begin
                    state_d               = RC_DRAIN;
                    cause_d               = '0;
                    cause_d[RC_CAUSE_SW]  = sw_req_i;
                    cause_d[RC_CAUSE_DBG] = dbg_req_i;
                    cause_d[RC_CAUSE_WDT] = wdt_expire_c;
                end
            end
            RC_DRAIN: begin
                if (quiesce_ack_i) begin
                    state_d = RC_HOLD;
                end else if (tmo_zero_c) begin
                    state_d               = RC_HOLD;
                    cause_d[RC_CAUSE_TMO] = 1'b1;
                end
            end
            default: begin
                state_d = RC_HOLD;
            end
        endcase
        rst_n_d   = (state_d == RC_HOLD) ? RST_ACTIVE : RST_RELEASE;
        quiesce_d = (state_d == RC_DRAIN);
    end

    assign rst_n_o       = rst_n_q;
    assign quiesce_req_o = quiesce_q;
    assign cause_o       = cause_q;

endmodule
